// File: rtl/mux_n_to_1_scan.sv
// Registered N:1 channel selector with direct select or a free-running scan pointer.
// Latency: 1 cycle from data_in/sel to f, ch_out, valid_out; wrap is registered alongside.
// Backpressure: none; en=0 freezes every register and forces wrap low.
//
// Ports:
//   clk, rst   rising-edge clock, asynchronous active-high reset
//   data_in    CHANNELS packed words, channel k at [k*WIDTH +: WIDTH]
//   sel        direct-mode select / scan-mode load value
//   mode       0 = direct, 1 = scan
//   en         clock enable for all state
//   load       scan mode only: jump the pointer to sel
//   f          registered selected word
//   ch_out     channel index f came from
//   valid_out  f came from a legal channel
//   wrap       one-cycle pulse when the scan pointer wraps to 0
module mux_n_to_1_scan #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2,
    parameter int HOLD     = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      mode,
    input  logic                      en,
    input  logic                      load,
    output logic [WIDTH-1:0]          f,
    output logic [SEL_W-1:0]          ch_out,
    output logic                      valid_out,
    output logic                      wrap
);

    // Dwell counter needs at least one bit even when HOLD=1.
    localparam int DW_W = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(HOLD - 1);
    localparam logic [SEL_W-1:0] CH_LAST    = SEL_W'(CHANNELS - 1);

    logic [SEL_W-1:0] ptr;
    logic [DW_W-1:0]  dwell;
    logic             mode_q;

    logic [WIDTH-1:0] sel_dat;
    logic [WIDTH-1:0] ptr_dat;
    logic             sel_legal;

    // Explicit compare-and-pick so indices >= CHANNELS yield zero
    // rather than reading past the packed vector.
    function automatic logic [WIDTH-1:0] pick(input logic [CHANNELS*WIDTH-1:0] d,
                                              input logic [SEL_W-1:0]          idx);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (idx == SEL_W'(k)) begin
                r = d[k*WIDTH +: WIDTH];
            end
        end
        return r;
    endfunction

    function automatic logic is_legal(input logic [SEL_W-1:0] idx);
        logic r;
        r = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (idx == SEL_W'(k)) begin
                r = 1'b1;
            end
        end
        return r;
    endfunction

    always_comb begin
        sel_dat   = pick(data_in, sel);
        ptr_dat   = pick(data_in, ptr);
        sel_legal = is_legal(sel);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f         <= '0;
            ch_out    <= '0;
            valid_out <= 1'b0;
            wrap      <= 1'b0;
            ptr       <= '0;
            dwell     <= '0;
            mode_q    <= 1'b0;
        end else if (en) begin
            mode_q <= mode;
            if (!mode) begin
                // Direct mode; also covers the scan->direct exit edge.
                f         <= sel_legal ? sel_dat : '0;
                ch_out    <= sel;
                valid_out <= sel_legal;
                wrap      <= 1'b0;
                ptr       <= '0;
                dwell     <= '0;
            end else begin
                // Output always reflects the pointer value before this edge.
                f         <= ptr_dat;
                ch_out    <= ptr;
                valid_out <= 1'b1;
                if (!mode_q) begin
                    // Mode entry restarts the scan from channel 0.
                    ptr   <= '0;
                    dwell <= '0;
                    wrap  <= 1'b0;
                end else if (load) begin
                    ptr   <= sel_legal ? sel : '0;
                    dwell <= '0;
                    wrap  <= 1'b0;
                end else if (dwell == DWELL_LAST) begin
                    dwell <= '0;
                    if (ptr == CH_LAST) begin
                        ptr  <= '0;
                        wrap <= 1'b1;
                    end else begin
                        ptr  <= ptr + SEL_W'(1);
                        wrap <= 1'b0;
                    end
                end else begin
                    dwell <= dwell + DW_W'(1);
                    wrap  <= 1'b0;
                end
            end
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_n_to_1_scan.sv
module tb_mux_n_to_1_scan;

    logic        clk = 1'b0;
    logic        rst;

    // Instance A: 4 channels, HOLD=3
    logic [31:0] data_in_a;
    logic [1:0]  sel_a;
    logic        mode_a, en_a, load_a;
    logic [7:0]  f_a;
    logic [1:0]  ch_a;
    logic        vld_a, wrap_a;

    // Instance B: 3 channels, HOLD=1
    logic [23:0] data_in_b;
    logic [1:0]  sel_b;
    logic        mode_b, en_b, load_b;
    logic [7:0]  f_b;
    logic [1:0]  ch_b;
    logic        vld_b, wrap_b;

    int vectors    = 0;
    int miscompares = 0;
    logic [11:0] exp_v;

    always #5 clk = ~clk;

    mux_n_to_1_scan #(.WIDTH(8), .CHANNELS(4), .SEL_W(2), .HOLD(3)) dut_a (
        .clk(clk), .rst(rst), .data_in(data_in_a), .sel(sel_a), .mode(mode_a),
        .en(en_a), .load(load_a), .f(f_a), .ch_out(ch_a), .valid_out(vld_a), .wrap(wrap_a)
    );

    mux_n_to_1_scan #(.WIDTH(8), .CHANNELS(3), .SEL_W(2), .HOLD(1)) dut_b (
        .clk(clk), .rst(rst), .data_in(data_in_b), .sel(sel_b), .mode(mode_b),
        .en(en_b), .load(load_b), .f(f_b), .ch_out(ch_b), .valid_out(vld_b), .wrap(wrap_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] byte_a(input int ch);
        return 8'h11 * 8'(ch + 1);
    endfunction

    function automatic logic [7:0] byte_b(input int ch);
        return (ch == 0) ? 8'hAA : (ch == 1) ? 8'hBB : 8'hCC;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vectors++;
        if ({f_a, ch_a, vld_a, wrap_a} !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_a: got %h want %h", {f_a, ch_a, vld_a, wrap_a}, 12'h000);
        end
        vectors++;
        if ({f_b, ch_b, vld_b, wrap_b} !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_b: got %h want %h", {f_b, ch_b, vld_b, wrap_b}, 12'h000);
        end
        rst = 1'b0;
    endtask

    task automatic test_direct();
        sel_a = 2'd2;
        tick();
        exp_v = {8'h33, 2'd2, 1'b1, 1'b0};
        vectors++;
        if ({f_a, ch_a, vld_a, wrap_a} !== exp_v) begin
            miscompares++;
            $display("FAIL direct_sel2: got %h want %h", {f_a, ch_a, vld_a, wrap_a}, exp_v);
        end
        sel_a = 2'd0;
        tick();
        exp_v = {8'h11, 2'd0, 1'b1, 1'b0};
        vectors++;
        if ({f_a, ch_a, vld_a, wrap_a} !== exp_v) begin
            miscompares++;
            $display("FAIL direct_sel0: got %h want %h", {f_a, ch_a, vld_a, wrap_a}, exp_v);
        end
        data_in_a = 32'hA0B0C0D0;
        tick();
        exp_v = {8'hD0, 2'd0, 1'b1, 1'b0};
        vectors++;
        if ({f_a, ch_a, vld_a, wrap_a} !== exp_v) begin
            miscompares++;
            $display("FAIL direct_newdata: got %h want %h", {f_a, ch_a, vld_a, wrap_a}, exp_v);
        end
        data_in_a = 32'h44332211;
        sel_a = 2'd3;
        tick();
        exp_v = {8'h44, 2'd3, 1'b1, 1'b0};
        vectors++;
        if ({f_a, ch_a, vld_a, wrap_a} !== exp_v) begin
            miscompares++;
            $display("FAIL direct_sel3: got %h want %h", {f_a, ch_a, vld_a, wrap_a}, exp_v);
        end
    endtask

    task automatic test_illegal();
        sel_b = 2'd3;
        tick();
        exp_v = {8'h00, 2'd3, 1'b0, 1'b0};
        vectors++;
        if ({f_b, ch_b, vld_b, wrap_b} !== exp_v) begin
            miscompares++;
            $display("FAIL illegal_sel3: got %h want %h", {f_b, ch_b, vld_b, wrap_b}, exp_v);
        end
        sel_b = 2'd1;
        tick();
        exp_v = {8'hBB, 2'd1, 1'b1, 1'b0};
        vectors++;
        if ({f_b, ch_b, vld_b, wrap_b} !== exp_v) begin
            miscompares++;
            $display("FAIL illegal_recover: got %h want %h", {f_b, ch_b, vld_b, wrap_b}, exp_v);
        end
    endtask

    // Edge N is the mode-entry edge: ch 0 for N..N+3, then 3 edges per channel.
    task automatic test_scan();
        int ch;
        mode_a = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            ch = (k < 4) ? 0 : (((k - 4) / 3 + 1) % 4);
            exp_v = {byte_a(ch), 2'(ch), 1'b1, (k == 12)};
            vectors++;
            if ({f_a, ch_a, vld_a, wrap_a} !== exp_v) begin
                miscompares++;
                $display("FAIL scan[%0d]: got %h want %h", k, {f_a, ch_a, vld_a, wrap_a}, exp_v);
            end
        end
    endtask

    task automatic test_load();
        tick();                                   // ptr=1, dwell 0->1
        exp_v = {8'h22, 2'd1, 1'b1, 1'b0};
        vectors++;
        if ({f_a, ch_a, vld_a, wrap_a} !== exp_v) begin
            miscompares++;
            $display("FAIL load_pre: got %h want %h", {f_a, ch_a, vld_a, wrap_a}, exp_v);
        end
        sel_a  = 2'd3;
        load_a = 1'b1;
        tick();                                   // output from old ptr, ptr<=3
        load_a = 1'b0;
        sel_a  = 2'd0;
        vectors++;
        if ({f_a, ch_a, vld_a, wrap_a} !== exp_v) begin
            miscompares++;
            $display("FAIL load_edge: got %h want %h", {f_a, ch_a, vld_a, wrap_a}, exp_v);
        end
        for (int k = 1; k <= 3; k++) begin
            tick();
            exp_v = {8'h44, 2'd3, 1'b1, (k == 3)};
            vectors++;
            if ({f_a, ch_a, vld_a, wrap_a} !== exp_v) begin
                miscompares++;
                $display("FAIL load_after[%0d]: got %h want %h", k, {f_a, ch_a, vld_a, wrap_a}, exp_v);
            end
        end
        en_a = 1'b0;
        tick();
        exp_v = {8'h44, 2'd3, 1'b1, 1'b0};
        vectors++;
        if ({f_a, ch_a, vld_a, wrap_a} !== exp_v) begin
            miscompares++;
            $display("FAIL wrap_clear_en0: got %h want %h", {f_a, ch_a, vld_a, wrap_a}, exp_v);
        end
        en_a = 1'b1;
        tick();                                   // ptr 0, dwell 0->1
        exp_v = {8'h11, 2'd0, 1'b1, 1'b0};
        vectors++;
        if ({f_a, ch_a, vld_a, wrap_a} !== exp_v) begin
            miscompares++;
            $display("FAIL load_wrapped: got %h want %h", {f_a, ch_a, vld_a, wrap_a}, exp_v);
        end
    endtask

    // Frozen at ptr=0 dwell=1: two more ch0 edges remain after resume.
    task automatic test_enable();
        en_a = 1'b0;
        data_in_a = 32'hDDCCBBAA;
        for (int k = 0; k < 5; k++) begin
            tick();
            exp_v = {8'h11, 2'd0, 1'b1, 1'b0};
            vectors++;
            if ({f_a, ch_a, vld_a, wrap_a} !== exp_v) begin
                miscompares++;
                $display("FAIL freeze[%0d]: got %h want %h", k, {f_a, ch_a, vld_a, wrap_a}, exp_v);
            end
        end
        data_in_a = 32'h44332211;
        en_a = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            exp_v = (k < 2) ? {8'h11, 2'd0, 1'b1, 1'b0} : {8'h22, 2'd1, 1'b1, 1'b0};
            vectors++;
            if ({f_a, ch_a, vld_a, wrap_a} !== exp_v) begin
                miscompares++;
                $display("FAIL resume[%0d]: got %h want %h", k, {f_a, ch_a, vld_a, wrap_a}, exp_v);
            end
        end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 2; k++) begin
            tick();
            exp_v = {8'h22, 2'd1, 1'b1, 1'b0};
            vectors++;
            if ({f_a, ch_a, vld_a, wrap_a} !== exp_v) begin
                miscompares++;
                $display("FAIL pre_rst[%0d]: got %h want %h", k, {f_a, ch_a, vld_a, wrap_a}, exp_v);
            end
        end
        #2;
        rst = 1'b1;                               // ptr=2, between edges
        #1;
        vectors++;
        if ({f_a, ch_a, vld_a, wrap_a} !== 12'h000) begin
            miscompares++;
            $display("FAIL async_rst: got %h want %h", {f_a, ch_a, vld_a, wrap_a}, 12'h000);
        end
        tick();
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            exp_v = {8'h11, 2'd0, 1'b1, 1'b0};
            vectors++;
            if ({f_a, ch_a, vld_a, wrap_a} !== exp_v) begin
                miscompares++;
                $display("FAIL post_rst[%0d]: got %h want %h", k, {f_a, ch_a, vld_a, wrap_a}, exp_v);
            end
        end
    endtask

    // HOLD=1 on 3 channels: pointer advances every edge and never reaches 3.
    task automatic test_hold1();
        int ch;
        mode_b = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            ch = (k == 0) ? 0 : ((k - 1) % 3);
            exp_v = {byte_b(ch), 2'(ch), 1'b1, (k >= 1) && ((k - 1) % 3 == 2)};
            vectors++;
            if ({f_b, ch_b, vld_b, wrap_b} !== exp_v) begin
                miscompares++;
                $display("FAIL hold1[%0d]: got %h want %h", k, {f_b, ch_b, vld_b, wrap_b}, exp_v);
            end
        end
        sel_b  = 2'd3;
        load_b = 1'b1;
        tick();
        load_b = 1'b0;
        exp_v = {8'hAA, 2'd0, 1'b1, 1'b0};
        vectors++;
        if ({f_b, ch_b, vld_b, wrap_b} !== exp_v) begin
            miscompares++;
            $display("FAIL load_illegal_edge: got %h want %h", {f_b, ch_b, vld_b, wrap_b}, exp_v);
        end
        tick();
        vectors++;
        if ({f_b, ch_b, vld_b, wrap_b} !== exp_v) begin
            miscompares++;
            $display("FAIL load_illegal_ptr: got %h want %h", {f_b, ch_b, vld_b, wrap_b}, exp_v);
        end
        mode_b = 1'b0;
        sel_b  = 2'd2;
        tick();
        exp_v = {8'hCC, 2'd2, 1'b1, 1'b0};
        vectors++;
        if ({f_b, ch_b, vld_b, wrap_b} !== exp_v) begin
            miscompares++;
            $display("FAIL mode_exit: got %h want %h", {f_b, ch_b, vld_b, wrap_b}, exp_v);
        end
        mode_b = 1'b1;
        tick();
        exp_v = {8'hAA, 2'd0, 1'b1, 1'b0};
        vectors++;
        if ({f_b, ch_b, vld_b, wrap_b} !== exp_v) begin
            miscompares++;
            $display("FAIL reentry: got %h want %h", {f_b, ch_b, vld_b, wrap_b}, exp_v);
        end
    endtask

    initial begin
        rst       = 1'b1;
        data_in_a = 32'h44332211;
        sel_a     = 2'd0;
        mode_a    = 1'b0;
        en_a      = 1'b1;
        load_a    = 1'b0;
        data_in_b = 24'hCCBBAA;
        sel_b     = 2'd0;
        mode_b    = 1'b0;
        en_b      = 1'b1;
        load_b    = 1'b0;

        test_reset();
        test_direct();
        test_illegal();
        test_scan();
        test_load();
        test_enable();
        test_async_reset();
        test_hold1();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mux_n_to_1_scan.md
Name: mux_n_to_1_scan

Overview:
- Parametrised, registered successor to the 2:1 combinational mux.
- Selects one of CHANNELS data words of WIDTH bits in one of two modes:
  - direct mode: external select.
  - scan mode: an internal pointer cycles through the channels, dwelling HOLD cycles on each.
- Output is registered, with a valid flag and the channel index. Used as the shared data-path selector feeding monitors and display logic in the lab designs.

Parameters:
- WIDTH, 8, bits per channel.
- CHANNELS, 4, number of input channels (2..16).
- SEL_W, 2, select/pointer width; must satisfy 2**SEL_W >= CHANNELS.
- HOLD, 3, clock cycles spent on each channel in scan mode (>= 1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset.
- data_in  input  CHANNELS*WIDTH  packed channels; channel k occupies bits [k*WIDTH +: WIDTH].
- sel  input  SEL_W  direct-mode select; scan-mode load value.
- mode  input  1  0 = direct, 1 = scan.
- en  input  1  clock enable; when 0 all registers hold.
- load  input  1  scan mode only: force pointer to sel.
- f  output  WIDTH  registered selected data.
- ch_out  output  SEL_W  channel index that f came from.
- valid_out  output  1  f holds data from a legal channel.
- wrap  output  1  one-cycle pulse when the scan pointer wraps CHANNELS-1 -> 0.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: f=0, ch_out=0, valid_out=0, wrap=0, ptr=0, dwell=0, mode_q=0. Reset mid-operation takes effect immediately, regardless of clk or en.
- en=0: f, ch_out, valid_out, ptr, dwell and mode_q all hold; wrap=0.
- Direct mode (mode=0, en=1):
  - Latency 1: at the edge, f <= data_in[sel], ch_out <= sel, valid_out <= 1.
  - sel >= CHANNELS (illegal): f <= 0, ch_out <= sel, valid_out <= 0.
  - ptr and dwell are held at 0; wrap=0.
- Scan mode (mode=1, en=1):
  - Each edge: f <= data_in[ptr], ch_out <= ptr, valid_out <= 1. f therefore shows the channel whose pointer value was current before the edge.
  - dwell counts 0..HOLD-1. At dwell==HOLD-1: dwell <= 0 and ptr <= ptr+1, or 0 if ptr==CHANNELS-1. Otherwise dwell <= dwell+1.
  - wrap <= 1 on the edge where ptr goes CHANNELS-1 -> 0; otherwise wrap <= 0.
- Mode entry: mode_q registers mode when en=1. The first enabled edge with mode=1 and mode_q=0 forces ptr <= 0, dwell <= 0, wrap <= 0; f still loads data_in[ptr] (ptr=0 from direct mode).
- load (scan mode, not mode entry):
  - ptr <= sel, dwell <= 0, wrap <= 0. f loads data_in[current ptr] on the same edge.
  - If sel >= CHANNELS, ptr <= 0.
  - Priority: rst > mode entry > load > normal dwell/advance. load is ignored in direct mode.
- Mode exit (1 -> 0): direct behaviour applies on that same edge; ptr and dwell clear to 0.
- HOLD=1: the pointer advances every enabled cycle.
- CHANNELS not a power of two: the pointer never visits indices >= CHANNELS.
- data_in changes are sampled only at the edge; no combinational path from any input to f.

Test Plan:
1. Direct mode, WIDTH=8, CHANNELS=4, data_in={8'h44,8'h33,8'h22,8'h11}, sel=2, en=1 -> after 1 edge: f=8'h33, ch_out=2, valid_out=1. Change sel to 0 -> next edge f=8'h11.
2. Illegal select, CHANNELS=3, SEL_W=2, sel=3 -> f=0, valid_out=0, ch_out=3. Then sel=1 -> next edge valid_out=1, f=data_in[1].
3. Scan, HOLD=3, mode 0->1 at edge N -> ch_out = 0 for edges N..N+3, 1 for N+4..N+6, 2 for N+7..N+9, 3 for N+10..N+12, 0 for N+13..N+15. wrap=1 only on edge N+12 (ptr 3->0).
4. Scan with load: sel=3, load=1 pulsed at the dwell=1 edge while ptr=1 -> ptr=3, dwell=0. Three edges later ptr wraps to 0 with wrap=1.
5. en low for 5 cycles mid-dwell in scan mode -> f, ch_out, ptr, dwell frozen, wrap=0. Scan resumes with the remaining dwell count intact.
6. Assert rst asynchronously mid-scan (ptr=2, between edges) -> f=0, ch_out=0, valid_out=0, wrap=0 immediately. After release with mode=1 held: valid_out=1 and ch_out=0 at the first edge (mode-entry restart).
